instr_encoder: RTL and testbench

Pipelined RV32I instruction encoder: the inverse of the OTTER immediate generator. It accepts decoded instruction fields and a full 32-bit immediate, scatters the immediate bits into their format-specific positions, and emits a packed 32-bit instruction word. It sits between the debug/boot-loader command path and the instruction memory write port, and is used to inject instructions. It has a 2-stage valid/ready pipeline, full throughput, and an optional immediate legality check with a saturating error counter.

---
 rtl/otter_enc_pkg.sv | 35 +++
 rtl/imm_pack.sv | 53 +++++
 rtl/instr_encoder.sv | 89 ++++++++
 tb/tb_instr_encoder.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_enc_pkg.sv
// Shared types and helpers for the RV32I instruction encoder.
// The IMM_RANGE_CHECK_EN build option is consumed by imm_pack, not here.
package otter_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // fmt is kept raw so the illegal codes 6/7 survive to the packer.
  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } enc_fields_t;

  // True when v is the sign extension of its low 'width' bits.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned width);
    logic [31:0] hi;
    hi = $signed(v) >>> (width - 1);
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational packer: scatters immediate bits into the RV32I format layout.
// IMM_RANGE_CHECK_EN adds the immediate legality check; otherwise only bad fmt errors.
module imm_pack
  import otter_enc_pkg::*;
(
  input  enc_fields_t fields_i,
  output logic [31:0] instr_o,
  output logic        err_o
);

  logic [31:0] imm;
  logic        fmt_bad;
  logic        imm_bad;

  assign imm = fields_i.imm;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    instr_o = NOP_INSTR;
    fmt_bad = 1'b0;
    case (fields_i.fmt)
      FMT_R: instr_o = {fields_i.funct7, fields_i.rs2, fields_i.rs1, fields_i.funct3,
                        fields_i.rd, fields_i.opcode};
      FMT_I: instr_o = {imm[11:0], fields_i.rs1, fields_i.funct3, fields_i.rd, fields_i.opcode};
      FMT_S: instr_o = {imm[11:5], fields_i.rs2, fields_i.rs1, fields_i.funct3,
                        imm[4:0], fields_i.opcode};
      FMT_B: instr_o = {imm[12], imm[10:5], fields_i.rs2, fields_i.rs1, fields_i.funct3,
                        imm[4:1], imm[11], fields_i.opcode};
      FMT_U: instr_o = {imm[31:12], fields_i.rd, fields_i.opcode};
      FMT_J: instr_o = {imm[20], imm[10:1], imm[11], imm[19:12], fields_i.rd, fields_i.opcode};
      default: fmt_bad = 1'b1;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // Illegal immediates are still packed by truncation above; only the flag differs.
  always_comb begin
    imm_bad = 1'b0;
    case (fields_i.fmt)
      FMT_I, FMT_S: imm_bad = !fits_signed(imm, 12);
      FMT_B:        imm_bad = !fits_signed(imm, 13) || imm[0];
      FMT_U:        imm_bad = |imm[11:0];
      FMT_J:        imm_bad = !fits_signed(imm, 21) || imm[0];
      default:      imm_bad = 1'b0;
    endcase
  end
`else
  assign imm_bad = 1'b0;
`endif

  assign err_o = fmt_bad | imm_bad;

endmodule

// File: rtl/instr_encoder.sv
// Two-stage valid/ready RV32I instruction encoder with saturating error counter.
// Define IMM_RANGE_CHECK_EN to flag out-of-range immediates as well as illegal fmt.
module instr_encoder
  import otter_enc_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           fmt,
  input  logic [6:0]           opcode,
  input  logic [4:0]           rd,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic [31:0]          imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  enc_fields_t            fields_d, fields_q;
  logic                   v1_q, v2_q;
  logic [31:0]            pack_instr, instr_q;
  logic                   pack_err, err_q;
  logic                   ld1, ld2;
  logic [ERR_CNT_W-1:0]   err_cnt_d, err_cnt_q;

  // Each stage advances when it is empty or its consumer is taking its word.
  assign ld2      = !v2_q || out_ready;
  assign ld1      = !v1_q || ld2;
  assign in_ready = !v1_q || !v2_q || out_ready;

  assign fields_d = '{fmt: fmt, opcode: opcode, rd: rd, rs1: rs1, rs2: rs2,
                      funct3: funct3, funct7: funct7, imm: imm};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      v1_q     <= 1'b0;
      fields_q <= '0;
    end else if (ld1) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      v1_q <= in_valid;
      if (in_valid) fields_q <= fields_d;
    end
  end

  imm_pack u_imm_pack (
    .fields_i (fields_q),
    .instr_o  (pack_instr),
    .err_o    (pack_err)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      // NOTE: payload is reset too, so out_instr/out_err read 0 straight after reset.
      v2_q    <= 1'b0;
      instr_q <= '0;
      err_q   <= 1'b0;
    end else if (ld2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        instr_q <= pack_instr;
        err_q   <= pack_err;
      end
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (v2_q && out_ready && err_q && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign out_valid = v2_q;
  assign out_instr = instr_q;
  assign out_err   = err_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus pushes expected words, a monitor pops them.
// Expected values come from an arithmetic model of the RV32I formats.
module tb_instr_encoder;
  import otter_enc_pkg::*;

  localparam int W = 8;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    fmt = '0;
  logic [6:0]    opcode = '0;
  logic [4:0]    rd = '0;
  logic [4:0]    rs1 = '0;
  logic [4:0]    rs2 = '0;
  logic [2:0]    funct3 = '0;
  logic [6:0]    funct7 = '0;
  logic [31:0]   imm = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_instr;
  logic          out_err;
  logic [W-1:0]  err_count;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   deliv_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   mdl_cnt = 0;

  instr_encoder #(.ERR_CNT_W(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .err_count(err_count)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  // Reference model: builds the word field by field with shifts and checks ranges numerically.
  function automatic exp_t model(input enc_fields_t f);
    exp_t        e;
    logic [31:0] im;
    int          si;
    logic        bad;
    logic        chk;
`ifdef IMM_RANGE_CHECK_EN
    chk = 1'b1;
`else
    chk = 1'b0;
`endif
    im  = f.imm;
    si  = int'($signed(f.imm));
    bad = 1'b0;
    e.err = 1'b0;
    case (int'(f.fmt))
      0: e.instr = 32'(f.opcode) | (32'(f.rd) << 7) | (32'(f.funct3) << 12) | (32'(f.rs1) << 15)
                   | (32'(f.rs2) << 20) | (32'(f.funct7) << 25);
      1: begin
        e.instr = 32'(f.opcode) | (32'(f.rd) << 7) | (32'(f.funct3) << 12) | (32'(f.rs1) << 15)
                  | ((im & 32'hFFF) << 20);
        bad = (si < -2048) || (si > 2047);
      end
      2: begin
        e.instr = 32'(f.opcode) | ((im & 32'h1F) << 7) | (32'(f.funct3) << 12) | (32'(f.rs1) << 15)
                  | (32'(f.rs2) << 20) | (((im >> 5) & 32'h7F) << 25);
        bad = (si < -2048) || (si > 2047);
      end
      3: begin
        e.instr = 32'(f.opcode) | (((im >> 11) & 32'h1) << 7) | (((im >> 1) & 32'hF) << 8)
                  | (32'(f.funct3) << 12) | (32'(f.rs1) << 15) | (32'(f.rs2) << 20)
                  | (((im >> 5) & 32'h3F) << 25) | (((im >> 12) & 32'h1) << 31);
        bad = (si < -4096) || (si > 4095) || ((im % 2) != 0);
      end
      4: begin
        e.instr = (im & 32'hFFFF_F000) | (32'(f.rd) << 7) | 32'(f.opcode);
        bad = (im % 4096) != 0;
      end
      5: begin
        e.instr = 32'(f.opcode) | (32'(f.rd) << 7) | (((im >> 12) & 32'hFF) << 12)
                  | (((im >> 11) & 32'h1) << 20) | (((im >> 1) & 32'h3FF) << 21)
                  | (((im >> 20) & 32'h1) << 31);
        bad = (si < -(1 << 20)) || (si >= (1 << 20)) || ((im % 2) != 0);
      end
      default: begin
        e.instr = 32'h0000_0013;
        e.err   = 1'b1;
      end
    endcase
    if (bad && chk) e.err = 1'b1;
    return e;
  endfunction

  function automatic enc_fields_t mk(input int f, input int op, input int d, input int s1,
                                     input int s2, input int f3, input int f7, input logic [31:0] im);
    enc_fields_t r;
    r.fmt = 3'(f);  r.opcode = 7'(op); r.rd = 5'(d); r.rs1 = 5'(s1); r.rs2 = 5'(s2);
    r.funct3 = 3'(f3); r.funct7 = 7'(f7); r.imm = im;
    return r;
  endfunction

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (RST_N && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("instr", out_instr, e.instr);
        check("err", 32'(out_err), 32'(e.err));
        if (e.err && mdl_cnt < (1 << W) - 1) mdl_cnt++;
        deliv_q.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the word has been accepted.
  task automatic send(input enc_fields_t f, input logic [31:0] ei, input logic ee,
                      input int release_after);
    int   n;
    exp_t e;
    n = 0;
    fmt = f.fmt; opcode = f.opcode; rd = f.rd; rs1 = f.rs1; rs2 = f.rs2;
    funct3 = f.funct3; funct7 = f.funct7; imm = f.imm;
    in_valid = 1'b1;
    @(negedge CLK);
    while (!in_ready && n < 500) begin
      step();
      n++;
      if (n >= release_after) out_ready = 1'b1;
      @(negedge CLK);
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      e.instr = ei;
      e.err   = ee;
      exp_q.push_back(e);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge CLK);
    step();
  endtask

  initial begin : stim
    enc_fields_t f;
    exp_t        e;
    logic        ee;
    logic [31:0] eq;
    int          sel;

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    step();
    RST_N = 1'b1;
    step();
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Single I-type word and its latency
    fmt = 3'd1; opcode = 7'h13; rd = 5'd1; rs1 = 5'd0; funct3 = 3'd0; imm = 32'd5;
    in_valid = 1'b1;
    e.instr = 32'h0050_0093; e.err = 1'b0;
    exp_q.push_back(e);
    step();
    in_valid = 1'b0;
    @(negedge CLK);
    check("latency_not_early", 32'(out_valid), 32'd0);
    @(negedge CLK);
    check("latency_two", 32'(out_valid), 32'd1);
    drain();

    // Back-to-back stream of four formats
    deliv_q.delete();
    send(mk(2, 7'h23, 0, 3, 2, 2, 0, 32'd8), 32'h0021_A423, 1'b0, 0);
    send(mk(3, 7'h63, 0, 0, 0, 0, 0, 32'hFFFF_FFFC), 32'hFE00_0EE3, 1'b0, 0);
    send(mk(5, 7'h6F, 1, 0, 0, 0, 0, 32'h0000_0800), 32'h0010_00EF, 1'b0, 0);
    send(mk(4, 7'h37, 5, 0, 0, 0, 0, 32'h1234_5000), 32'h1234_52B7, 1'b0, 0);
    drain();
    check("stream_count", 32'(deliv_q.size()), 32'd4);
    if (deliv_q.size() == 4)
      for (int i = 0; i < 3; i++)
        check("stream_consecutive", 32'(deliv_q[i+1] - deliv_q[i]), 32'd1);

    // I-type immediate 2048: out of range only when the check is built in
`ifdef IMM_RANGE_CHECK_EN
    ee = 1'b1;
`else
    ee = 1'b0;
`endif
    send(mk(1, 7'h13, 1, 0, 0, 0, 0, 32'd2048), 32'h8000_0093, ee, 0);
    drain();
    check("err_count_imm2048", 32'(err_count), 32'(ee));

    // Illegal fmt
    send(mk(7, 7'h33, 3, 4, 5, 1, 2, 32'hDEAD_BEEF), 32'h0000_0013, 1'b1, 0);
    drain();
    check("err_count_fmt7", 32'(err_count), 32'(mdl_cnt));

    // Stall during a 3-word burst
    out_ready = 1'b0;
    send(mk(0, 7'h33, 1, 2, 3, 0, 7'h20, 32'd0), 32'h4031_00B3, 1'b0, 99);
    send(mk(1, 7'h13, 2, 1, 0, 0, 0, 32'hFFFF_FFFF), 32'hFFF0_8113, 1'b0, 99);
    fmt = 3'd4; opcode = 7'h17; rd = 5'd7; imm = 32'hABCD_E000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_instr", out_instr, 32'h4031_00B3);
      step();
    end
    send(mk(4, 7'h17, 7, 0, 0, 0, 0, 32'hABCD_E000), 32'hABCD_E397, 1'b0, 0);
    drain();

    // Counter saturation
    for (int i = 0; i < (1 << W) + 3; i++)
      send(mk(6, 0, 0, 0, 0, 0, 0, 32'd0), 32'h0000_0013, 1'b1, 0);
    drain();
    check("err_count_saturated", 32'(err_count), 32'hFF);
    check("err_count_model", 32'(err_count), 32'(mdl_cnt));

    // Reset with both stages full
    out_ready = 1'b0;
    send(mk(0, 7'h33, 1, 1, 1, 0, 0, 32'd0), 32'h0010_80B3, 1'b0, 99);
    send(mk(6, 0, 0, 0, 0, 0, 0, 32'd0), 32'h0000_0013, 1'b1, 99);
    RST_N = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_err_count", 32'(err_count), 32'd0);
    exp_q.delete();
    mdl_cnt = 0;
    step();
    RST_N = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("post_rst_idle", 32'(out_valid), 32'd0);
    end
    step();

    // Randomized traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       eq = $urandom;
        1:       eq = 32'(int'($urandom_range(0, 8191)) - 4096);
        2:       eq = 32'(int'($urandom_range(0, 8191)) - 4096) & 32'hFFFF_FFFE;
        default: eq = $urandom & 32'hFFFF_F000;
      endcase
      f = mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 127)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 127)), eq);
      e = model(f);
      out_ready = ($urandom_range(0, 3) != 0);
      send(f, e.instr, e.err, int'($urandom_range(0, 3)));
      if ($urandom_range(0, 7) == 0) step();
    end
    drain();
    check("err_count_final", 32'(err_count), 32'(mdl_cnt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
